// File: rtl/regfile_pkg.sv
// Shared sizing and state encoding for the regfile write-port arbiter.
package regfile_pkg;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = $clog2(NUM_REGS);
    localparam int DATA_W   = 32;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester handshakes and regfile write-port signals of the write arbiter.
interface regfile_write_arbiter_if
    import regfile_pkg::*;
;
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_reg;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_reg;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              ctrl_writeEn;
    logic [ADDR_W-1:0] ctrl_writeReg;
    logic [DATA_W-1:0] data_writeReg;
    logic              init_done;

    modport master (
        output req0_valid, req0_reg, req0_data, req1_valid, req1_reg, req1_data,
        input  req0_ready, req1_ready, ctrl_writeEn, ctrl_writeReg, data_writeReg, init_done
    );

    modport slave (
        input  req0_valid, req0_reg, req0_data, req1_valid, req1_reg, req1_data,
        output req0_ready, req1_ready, ctrl_writeEn, ctrl_writeReg, data_writeReg, init_done
    );
endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-input round-robin grant; last_grant resets to 1 so requester 0 wins the first tie.
module rr_arbiter2 (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic valid0,
    input  logic valid1,
    output logic grant0,
    output logic grant1
);
    logic last_grant;

    assign grant0 = en & valid0 & (~valid1 | last_grant);
    assign grant1 = en & valid1 & (~valid0 | ~last_grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (grant0) begin
            last_grant <= 1'b0;
        end else if (grant1) begin
            last_grant <= 1'b1;
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the regfile write port: optional post-reset zero sweep, then round-robin
// arbitration between ALU writeback (req0) and load return (req1).
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                    clock,
    input  logic                    ctrl_reset,
    regfile_write_arbiter_if.slave  bus
);
    // state | meaning
    // INIT  | zero-clear sweep of r1..r31, requesters held off
    // RUN   | arbitrate requesters onto the write port
    localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_INIT : ST_RUN;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic              last_clr;
    logic              sweep_we;
    logic              arb_en;
    logic              grant0, grant1;
    logic              we_q;
    logic [ADDR_W-1:0] wreg_q;
    logic [DATA_W-1:0] wdata_q;
    logic              init_done_q;

    assign last_clr = (clr_cnt == ADDR_W'(NUM_REGS - 1));

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            state <= RESET_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: if (last_clr) state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = RESET_STATE;
        endcase
    end

    // Gating on init_done keeps ready low on the first cycle out of reset when the sweep is skipped.
    always_comb begin
        sweep_we = (state == ST_INIT);
        arb_en   = (state == ST_RUN) & init_done_q;
    end

    rr_arbiter2 u_arb (
        .clk    (clock),
        .rst_n  (ctrl_reset),
        .en     (arb_en),
        .valid0 (bus.req0_valid),
        .valid1 (bus.req1_valid),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            we_q        <= 1'b0;
            wreg_q      <= '0;
            wdata_q     <= '0;
            init_done_q <= 1'b0;
            clr_cnt     <= ADDR_W'(1);
        end else if (sweep_we) begin
            we_q    <= 1'b1;
            wreg_q  <= clr_cnt;
            wdata_q <= '0;
            if (last_clr) begin
                init_done_q <= 1'b1;
            end else begin
                clr_cnt <= clr_cnt + ADDR_W'(1);
            end
        end else begin
            init_done_q <= 1'b1;
            // r0 writes complete the handshake but never reach the regfile.
            if (grant0) begin
                we_q    <= (bus.req0_reg != '0);
                wreg_q  <= bus.req0_reg;
                wdata_q <= bus.req0_data;
            end else if (grant1) begin
                we_q    <= (bus.req1_reg != '0);
                wreg_q  <= bus.req1_reg;
                wdata_q <= bus.req1_data;
            end else begin
                we_q <= 1'b0;
            end
        end
    end

    assign bus.req0_ready    = grant0;
    assign bus.req1_ready    = grant1;
    assign bus.ctrl_writeEn  = we_q;
    assign bus.ctrl_writeReg = wreg_q;
    assign bus.data_writeReg = wdata_q;
    assign bus.init_done     = init_done_q;
endmodule
